// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one I2C write engine between NREQ requesters.
// Round-robin grant, one transaction in flight, ack timeout and a
// post-transaction idle gap before the next grant.
// Optional build macro I2C_ARB_PRIO0_EN: requester 0 takes fixed highest
// priority and leaves the round-robin pointer untouched when it wins.
//
// state | meaning
// IDLE  | no transaction; arbitrate among req_valid
// ISSUE | one-cycle i2c_req to the engine, timeout timer loaded
// WAIT  | waiting for i2c_ack or timeout terminal count
// GAP   | enforced idle gap before the next arbitration
module i2c_req_arbiter #(
    parameter int NREQ        = 4,
    parameter int GAP_CYC     = 1000,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                clk_100,
    input  logic                rst_100,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [32*NREQ-1:0]  req_data,
    output logic [NREQ-1:0]     req_done,
    output logic [NREQ-1:0]     req_err,
    output logic [31:0]         cfg_data,
    output logic                i2c_req,
    input  logic                i2c_ack,
    output logic                busy,
    output logic [2:0]          grant_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [2:0]       LAST_IDX = 3'(NREQ - 1);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        ptr;
    logic [TO_W-1:0]   to_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic              any_sel;
    logic              sel_rr;
    logic [2:0]        sel_idx;
    logic [3:0]        scan;
    logic [31:0]       sel_data;

    logic              ack_hit;
    logic              to_hit;
    logic              wait_exit;

    logic [NREQ-1:0]   grant_onehot;
    logic [NREQ-1:0]   done_nxt;
    logic [NREQ-1:0]   err_nxt;
    logic              i2c_req_nxt;
    logic              busy_nxt;

    // Both timers count down; a terminal count of zero ends WAIT / GAP.
    // An ack always beats the timeout on the same cycle.
    assign ack_hit   = (state == WAIT) && i2c_ack;
    assign to_hit    = (state == WAIT) && !i2c_ack && (to_cnt == '0);
    assign wait_exit = ack_hit || to_hit;

    // Round-robin search: first asserted request at or after ptr, wrapping.
    always_comb begin
        any_sel = 1'b0;
        sel_rr  = 1'b0;
        sel_idx = '0;
        scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + 4'(k);
            if (scan >= 4'(NREQ)) begin
                scan = scan - 4'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!any_sel && req_valid[j] && (scan == 4'(j))) begin
                    any_sel = 1'b1;
                    sel_rr  = 1'b1;
                    sel_idx = 3'(j);
                end
            end
        end
`ifdef I2C_ARB_PRIO0_EN
        if (req_valid[0]) begin
            any_sel = 1'b1;
            sel_rr  = 1'b0;
            sel_idx = '0;
        end
`endif
    end

    // Word of the selected requester.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == 3'(i)) begin
                sel_data = req_data[32*i +: 32];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_100 or negedge rst_100) begin
        if (!rst_100) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; with no gap configured WAIT returns straight to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_sel) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_exit) state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == 3'(i)) begin
                grant_onehot[i] = 1'b1;
            end
        end
        done_nxt    = ack_hit ? grant_onehot : '0;
        err_nxt     = to_hit  ? grant_onehot : '0;
        i2c_req_nxt = (state_nxt == ISSUE);
        busy_nxt    = (state_nxt != IDLE);
    end

    // Output registers.
    always_ff @(posedge clk_100 or negedge rst_100) begin
        if (!rst_100) begin
            req_done <= '0;
            req_err  <= '0;
            i2c_req  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            req_done <= done_nxt;
            req_err  <= err_nxt;
            i2c_req  <= i2c_req_nxt;
            busy     <= busy_nxt;
        end
    end

    // Grant capture, round-robin pointer and the two down-counters.
    always_ff @(posedge clk_100 or negedge rst_100) begin
        if (!rst_100) begin
            cfg_data  <= '0;
            grant_idx <= '0;
            ptr       <= '0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
        end else begin
            if ((state == IDLE) && any_sel) begin
                cfg_data  <= sel_data;
                grant_idx <= sel_idx;
                if (sel_rr) begin
                    ptr <= (sel_idx == LAST_IDX) ? 3'd0 : sel_idx + 3'd1;
                end
            end
            if (state == ISSUE) begin
                to_cnt <= TO_LOAD;
            end else if ((state == WAIT) && !wait_exit) begin
                to_cnt <= to_cnt - TO_W'(1);
            end
            if (wait_exit) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_i2c_req_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 4;
    localparam int TO   = 16;

    logic                clk_100 = 1'b0;
    logic                rst_100 = 1'b1;
    logic [NREQ-1:0]     req_valid;
    logic [32*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     req_done;
    logic [NREQ-1:0]     req_err;
    logic [31:0]         cfg_data;
    logic                i2c_req;
    logic                i2c_ack;
    logic                busy;
    logic [2:0]          grant_idx;

    always #5 clk_100 = ~clk_100;

    i2c_req_arbiter #(
        .NREQ        (NREQ),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_100   (clk_100),
        .rst_100   (rst_100),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_done  (req_done),
        .req_err   (req_err),
        .cfg_data  (cfg_data),
        .i2c_req   (i2c_req),
        .i2c_ack   (i2c_ack),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model: pointer, in-flight transaction and when arbitration reopens
    int m_ptr       = 0;
    int m_win       = 0;
    int m_out       = 0;
    int m_idle_from = 0;
    bit m_inflight  = 0;
    bit m_out_err   = 0;

    // engine / requester models
    int cur_delay = 10;
    int ack_cnt   = 0;
    bit stray     = 0;
    bit rand_mode = 0;
    logic [31:0] dat [NREQ];

    // observed transaction history
    int act_issue = -1000;
    int act_out   = -1000;
    int act_grant = 0;
    int issue_gap = 0;
    logic [NREQ-1:0] act_done;
    logic [NREQ-1:0] act_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = dat[i];
    endtask

    task automatic step();
        logic [NREQ-1:0] v, e_done, e_err, dropped;
        bit exp_req, exp_busy, prio_pick;
        @(negedge clk_100);
        cyc++;
        v = req_valid;
        exp_req = !m_inflight && (cyc - 1 >= m_idle_from) && (v != '0);
        if (exp_req) begin
            m_win = -1;
            prio_pick = 0;
`ifdef I2C_ARB_PRIO0_EN
            if (v[0]) begin
                m_win = 0;
                prio_pick = 1;
            end
`endif
            for (int k = 0; k < NREQ; k++) begin
                automatic int j = (m_ptr + k) % NREQ;
                if (m_win < 0 && v[j]) m_win = j;
            end
            if (!prio_pick) m_ptr = (m_win + 1) % NREQ;
            m_inflight = 1;
            if (cur_delay >= 1 && cur_delay <= TO) begin
                m_out = cyc + cur_delay + 1;
                m_out_err = 0;
            end else begin
                m_out = cyc + TO + 1;
                m_out_err = 1;
            end
        end
        e_done = '0;
        e_err  = '0;
        if (m_inflight && cyc == m_out) begin
            if (m_out_err) e_err[m_win] = 1'b1;
            else           e_done[m_win] = 1'b1;
        end
        exp_busy = m_inflight || (cyc < m_idle_from);
        chk("i2c_req", i2c_req, exp_req);
        if (exp_req) begin
            chk("grant_idx", grant_idx, m_win);
            chk("cfg_data", cfg_data, dat[m_win]);
        end
        chk("req_done", req_done, e_done);
        chk("req_err", req_err, e_err);
        chk("busy", busy, exp_busy);
        if (m_inflight && cyc == m_out) begin
            m_inflight  = 0;
            m_idle_from = cyc + GAP;
        end
        if (i2c_req) begin
            issue_gap = cyc - act_out;
            act_issue = cyc;
            act_grant = grant_idx;
        end
        if ((req_done | req_err) != '0) begin
            act_out  = cyc;
            act_done = req_done;
            act_err  = req_err;
        end
        // engine: ack cur_delay cycles after i2c_req; 0 = never
        i2c_ack = stray;
        stray = 0;
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) i2c_ack = 1'b1;
        end
        if (i2c_req) ack_cnt = cur_delay;
        // requesters drop on their done/err
        dropped   = req_valid & (req_done | req_err);
        req_valid = req_valid & ~dropped;
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && !dropped[i] && $urandom_range(7) == 0) begin
                    dat[i] = $urandom;
                    req_valid[i] = 1'b1;
                end
            end
            drive_data();
            cur_delay = $urandom_range(21, 1);
        end
    endtask

    task automatic wait_out(input int lim);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while ((req_done | req_err) == '0 && k < lim);
        chk("bounded_wait", ((req_done | req_err) != '0), 1);
    endtask

    task automatic drain(input int lim);
        int k;
        k = 0;
        while ((req_valid != '0 || busy) && k < lim) begin
            step();
            k++;
        end
        chk("drain_bounded", (req_valid == '0 && !busy), 1);
    endtask

    task automatic do_reset();
        @(negedge clk_100);
        cyc++;
        rst_100   = 1'b0;
        i2c_ack   = 1'b0;
        ack_cnt   = 0;
        stray     = 0;
        rand_mode = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_i2c_req", i2c_req, 0);
        chk("rst_done", req_done, 0);
        chk("rst_err", req_err, 0);
        chk("rst_cfg", cfg_data, 0);
        chk("rst_grant", grant_idx, 0);
        @(negedge clk_100);
        cyc++;
        req_valid   = '0;
        rst_100     = 1'b1;
        m_inflight  = 0;
        m_ptr       = 0;
        m_idle_from = cyc;
    endtask

    initial begin
        req_valid = '0;
        i2c_ack   = 1'b0;
        for (int i = 0; i < NREQ; i++) dat[i] = '0;
        drive_data();
        do_reset();

        // contention: all four held, each drops after its done
        for (int i = 0; i < NREQ; i++) dat[i] = $urandom;
        drive_data();
        cur_delay = 10;
        req_valid = 4'b1111;
        for (int t = 0; t < NREQ; t++) begin
            wait_out(80);
            chk("rr_order", act_grant, t);
            chk("rr_done", act_done, 1 << t);
            if (t > 0) chk("rr_gap", issue_gap, GAP + 1);
        end
        repeat (8) step();

        // single request
        dat[0] = 32'h78310311;
        drive_data();
        req_valid = 4'b0001;
        step();
        chk("single_req", i2c_req, 1);
        chk("single_cfg", cfg_data, 32'h78310311);
        wait_out(40);
        chk("single_done", req_done, 4'b0001);
        chk("single_lat", act_out - act_issue, 11);
        repeat (3) step();
        chk("single_busy_gap", busy, 1);
        step();
        chk("single_busy_low", busy, 0);

        // stray ack in IDLE
        repeat (4) step();
        stray = 1;
        repeat (3) step();
        chk("stray_busy", busy, 0);
        chk("stray_done", req_done, 0);

        // timeout on requester 2, then normal service
        cur_delay = 0;
        dat[2] = $urandom;
        drive_data();
        req_valid = 4'b0100;
        wait_out(60);
        chk("to_err", req_err, 4'b0100);
        chk("to_done", req_done, 0);
        chk("to_lat", act_out - act_issue, TO + 1);
        cur_delay = 10;
        dat[1] = $urandom;
        drive_data();
        req_valid = 4'b0010;
        wait_out(60);
        chk("recover_done", req_done, 4'b0010);

        // ack on the timeout terminal cycle wins
        cur_delay = TO;
        dat[3] = $urandom;
        drive_data();
        req_valid = 4'b1000;
        wait_out(60);
        chk("tie_done", req_done, 4'b1000);
        chk("tie_err", req_err, 0);

        // ack one cycle late: timeout, late ack lands in GAP
        cur_delay = TO + 1;
        req_valid = 4'b0001;
        wait_out(60);
        chk("late_err", req_err, 4'b0001);
        repeat (8) step();

        // reset mid-WAIT
        cur_delay = 0;
        req_valid = 4'b0100;
        repeat (4) step();
        chk("pre_rst_busy", busy, 1);
        do_reset();
        dat[1] = $urandom;
        dat[3] = $urandom;
        drive_data();
        cur_delay = 10;
        req_valid = 4'b1010;
        step();
        chk("post_rst_req", i2c_req, 1);
        chk("post_rst_grant", grant_idx, 1);
        wait_out(40);
        chk("post_rst_done", req_done, 4'b0010);
        drain(500);

        // requester 0 rises while 2 and 3 wait
        do_reset();
        for (int i = 0; i < NREQ; i++) dat[i] = $urandom;
        drive_data();
        cur_delay = 10;
        req_valid = 4'b1110;
        wait_out(40);
        chk("prio_first", act_grant, 1);
        req_valid[0] = 1'b1;
        wait_out(40);
`ifdef I2C_ARB_PRIO0_EN
        chk("prio_second", act_grant, 0);
`else
        chk("prio_second", act_grant, 2);
`endif
        drain(500);

        // random traffic with random engine latency (including 16/17 boundary)
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        cur_delay = 10;
        drain(2000);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
